// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared state/termination encodings and width defaults for the Wishbone memory slave
package wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_TERM   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        TERM_NONE = 2'd0,
        TERM_ACK  = 2'd1,
        TERM_ERR  = 2'd2,
        TERM_RTY  = 2'd3
    } term_e;

    localparam int DEF_DATA_W     = 8;
    localparam int DEF_ADDR_W     = 16;
    localparam int DEF_MEM_ADDR_W = 12;
    localparam int WAIT_CNT_W     = 4;

endpackage

// File: rtl/wb_addr_decode.sv
// rtl/wb_addr_decode.sv - combinational window match of a Wishbone address against the slave base
module wb_addr_decode
    import wb_pkg::*;
#(
    parameter int                ADDR_W     = DEF_ADDR_W,
    parameter int                MEM_ADDR_W = DEF_MEM_ADDR_W,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
    input  logic [ADDR_W-1:0] adr_i,
    output logic              in_range_o
);

    assign in_range_o = (adr_i >> MEM_ADDR_W) == (BASE_ADDR >> MEM_ADDR_W);

endmodule

// File: rtl/wb_mem_slave.sv
// rtl/wb_mem_slave.sv - Wishbone classic single-transfer slave driving a cs/we/oe synchronous memory
module wb_mem_slave
    import wb_pkg::*;
#(
    parameter int                DATA_W      = DEF_DATA_W,
    parameter int                ADDR_W      = DEF_ADDR_W,
    parameter int                MEM_ADDR_W  = DEF_MEM_ADDR_W,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                WAIT_STATES = 1,
    parameter bit                READ_ONLY   = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     adr_i,
    input  logic [DATA_W-1:0]     dat_i,
    output logic [DATA_W-1:0]     dat_o,
    input  logic                  we_i,
    input  logic                  stb_i,
    input  logic                  cyc_i,
    output logic                  ack_o,
    output logic                  err_o,
    output logic                  rty_o,
    input  logic                  mem_busy,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe,
    output logic [MEM_ADDR_W-1:0] mem_dir,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);

    state_e                state_q, state_d;
    term_e                 term_q, term_d;
    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
    logic                  cs_q, cs_d, we_q, we_d, oe_q, oe_d;
    logic [DATA_W-1:0]     dat_q, dat_d, wdata_q, wdata_d;
    logic [MEM_ADDR_W-1:0] dir_q, dir_d;
    logic                  in_range, req, reject;

    wb_addr_decode #(
        .ADDR_W     (ADDR_W),
        .MEM_ADDR_W (MEM_ADDR_W),
        .BASE_ADDR  (BASE_ADDR)
    ) u_addr_decode (
        .adr_i      (adr_i),
        .in_range_o (in_range)
    );

    assign req    = stb_i & cyc_i;
    assign reject = !in_range || (READ_ONLY && we_i);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            term_q  <= TERM_NONE;
            cnt_q   <= '0;
            cs_q    <= 1'b0;
            we_q    <= 1'b0;
            oe_q    <= 1'b0;
            dat_q   <= '0;
            wdata_q <= '0;
            dir_q   <= '0;
        end else begin
            state_q <= state_d;
            term_q  <= term_d;
            cnt_q   <= cnt_d;
            cs_q    <= cs_d;
            we_q    <= we_d;
            oe_q    <= oe_d;
            dat_q   <= dat_d;
            wdata_q <= wdata_d;
            dir_q   <= dir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req) state_d = (reject || mem_busy) ? ST_TERM : ST_ACCESS;
            end
            ST_ACCESS: begin
                if (!cyc_i)             state_d = ST_IDLE;
                else if (cnt_q == '0)   state_d = ST_TERM;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Terminations are only ever set on the transition into TERM, so each lasts one cycle.
    always_comb begin
        term_d  = TERM_NONE;
        cnt_d   = cnt_q;
        cs_d    = cs_q;
        we_d    = we_q;
        oe_d    = oe_q;
        dat_d   = dat_q;
        wdata_d = wdata_q;
        dir_d   = dir_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (reject) begin
                        term_d = TERM_ERR;
                    end else if (mem_busy) begin
                        term_d = TERM_RTY;
                    end else begin
                        dir_d   = adr_i[MEM_ADDR_W-1:0];
                        wdata_d = dat_i;
                        cs_d    = 1'b1;
                        we_d    = we_i;
                        oe_d    = !we_i;
                        cnt_d   = WAIT_CNT_W'(WAIT_STATES);
                    end
                end
            end
            ST_ACCESS: begin
                if (!cyc_i) begin
                    {cs_d, we_d, oe_d} = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - WAIT_CNT_W'(1);
                end else begin
                    term_d             = TERM_ACK;
                    {cs_d, we_d, oe_d} = '0;
                    if (!we_q) dat_d = mem_rdata;
                end
            end
            default: ;
        endcase
    end

    assign ack_o     = (term_q == TERM_ACK);
    assign err_o     = (term_q == TERM_ERR);
    assign rty_o     = (term_q == TERM_RTY);
    assign dat_o     = dat_q;
    assign mem_cs    = cs_q;
    assign mem_we    = we_q;
    assign mem_oe    = oe_q;
    assign mem_dir   = dir_q;
    assign mem_wdata = wdata_q;

endmodule

// File: doc/wb_mem_slave.md
Name: wb_mem_slave

Overview:
- Parametrised Wishbone classic single-transfer slave bridging the CPU's Wishbone master to an external synchronous memory (memdata-style cs/we/oe interface).
- Generalises the fixed 8-bit/12-bit memory slave in four ways:
  - configurable data and address widths;
  - base-address decoding with an error response;
  - programmable wait states;
  - retry on memory-busy, plus an optional read-only mode.
- Sits between syscon-clocked Wishbone fabric and one memory instance.

Parameters:
- DATA_W, 8, data bus width in bits.
- ADDR_W, 16, Wishbone address width.
- MEM_ADDR_W, 12, memory address width; window size is 2^MEM_ADDR_W.
- BASE_ADDR, 16'h0000, window base; must be aligned to 2^MEM_ADDR_W.
- WAIT_STATES, 1, extra memory cycles before data is valid (0..15).
- READ_ONLY, 0, when 1, writes to the window are answered with err.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- adr_i  in  ADDR_W  Wishbone address.
- dat_i  in  DATA_W  Wishbone write data.
- dat_o  out  DATA_W  Wishbone read data.
- we_i  in  1  write enable (1 = write).
- stb_i  in  1  strobe.
- cyc_i  in  1  bus cycle.
- ack_o  out  1  normal termination.
- err_o  out  1  error termination.
- rty_o  out  1  retry termination.
- mem_busy  in  1  memory not ready; request must be retried.
- mem_cs  out  1  memory chip select.
- mem_we  out  1  memory write enable.
- mem_oe  out  1  memory output enable.
- mem_dir  out  MEM_ADDR_W  memory address.
- mem_wdata  out  DATA_W  data to memory.
- mem_rdata  in  DATA_W  data from memory.

Behaviour:
- Clocking and reset:
  - Single clock domain `clk`; `reset` is asynchronous and active-high.
  - On reset: state = IDLE; ack_o, err_o, rty_o, mem_cs, mem_we, mem_oe = 0; dat_o, mem_dir, mem_wdata = 0; wait counter = 0.
  - Reset asserted mid-transfer aborts immediately with no termination signal.
- Request and address decode:
  - A request is stb_i & cyc_i sampled in IDLE.
  - in_range = (adr_i >> MEM_ADDR_W) == (BASE_ADDR >> MEM_ADDR_W).
- IDLE transitions, checked in priority order:
  - No request: stay in IDLE.
  - !in_range, or (READ_ONLY & we_i): go to TERM; err_o = 1 for one cycle; no memory strobes.
  - mem_busy: go to TERM; rty_o = 1 for one cycle; no memory strobes.
  - Otherwise go to ACCESS:
    - latch mem_dir = adr_i[MEM_ADDR_W-1:0] and mem_wdata = dat_i;
    - mem_cs = 1, mem_we = we_i, mem_oe = !we_i;
    - counter = WAIT_STATES.
- ACCESS:
  - If cyc_i = 0: abort to IDLE, drop all mem strobes, no ack.
  - Else if counter != 0: decrement counter.
  - Else (counter = 0): go to TERM; ack_o = 1; drop mem strobes; on a read, dat_o <= mem_rdata.
- TERM:
  - The termination output is high for exactly one cycle.
  - Next edge: all terminations = 0, return to IDLE.
- Timing:
  - ack_o rises WAIT_STATES+1 edges after the request edge.
  - Back-to-back transfers have one idle cycle between ack and the next accepted request.
  - mem strobes are high for WAIT_STATES+1 cycles.
- Output invariants:
  - ack_o, err_o and rty_o are mutually exclusive and registered (no combinational path from inputs).
  - dat_o holds its last read value; it is unchanged by writes, err or rty.
- Boundaries:
  - Highest in-window address (BASE + 2^MEM_ADDR_W − 1) succeeds.
  - BASE + 2^MEM_ADDR_W gives err.
  - stb_i held high through TERM is treated as a new request only after IDLE is re-entered.

Decomposition:
- Shared package wb_pkg holds:
  - state encoding localparams (IDLE, ACCESS, TERM);
  - the termination-type encoding;
  - default width constants.
- The address decoder is natural as sub-module wb_addr_decode (combinational in_range compare).
- FSM and counter stay in wb_mem_slave.

Test Plan:
- Read, WAIT_STATES=1, BASE=0:
  - preload mem[12'h005] = 8'hA5; adr_i = 16'h0005, we_i = 0.
  - Required: mem_cs/mem_oe high 2 cycles; ack_o = 1 on the 2nd edge after the request; dat_o = 8'hA5.
- Write:
  - adr_i = 16'h0FFF, dat_i = 8'h3C, we_i = 1.
  - Required: mem_we high 2 cycles with mem_dir = 12'hFFF; ack_o once.
  - A following read of 16'h0FFF returns 8'h3C.
- Out of range:
  - adr_i = 16'h1000.
  - Required: err_o pulses 1 cycle after the request; mem_cs never asserts; ack_o stays 0.
- Retry:
  - mem_busy = 1 with an in-range read.
  - Required: rty_o pulses once, no strobes.
  - Drop mem_busy and retry: ack_o is received.
- Abort and reset:
  - WAIT_STATES=3: drop cyc_i in the 2nd ACCESS cycle; required: strobes drop next edge, no termination, FSM in IDLE.
  - Repeat with reset asserted mid-ACCESS; required: all outputs 0 asynchronously.
- READ_ONLY=1:
  - write to 16'h0002; required: err_o pulses and memory is unchanged.
  - read of the same address; required: ack_o.
